// File: rtl/sr_latch_cmd_sched_if.sv
// rtl/sr_latch_cmd_sched_if.sv - requester handshake and SR-latch drive bundle
interface sr_latch_cmd_sched_if #(
    parameter int NREQ = 4,
    parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_set;
    logic [NREQ-1:0] req_ready;
    logic            sr_s;
    logic            sr_r;
    logic            q_shadow;
    logic            busy;
    logic            done;
    logic [GW-1:0]   done_id;
    logic            done_skip;

    modport master (
        output req_valid, req_set,
        input  req_ready, sr_s, sr_r, q_shadow, busy, done, done_id, done_skip
    );

    modport slave (
        input  req_valid, req_set,
        output req_ready, sr_s, sr_r, q_shadow, busy, done, done_id, done_skip
    );
endinterface

// File: rtl/sr_latch_cmd_sched.sv
// rtl/sr_latch_cmd_sched.sv - round-robin set/clear pulse scheduler for one SR latch
module sr_latch_cmd_sched #(
    parameter int  NREQ    = 4,
    parameter int  PULSE_W = 2,
    parameter int  GAP_W   = 1,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sr_latch_cmd_sched_if.slave   bus
);
    localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PUL_C = CW'(PULSE_W);
    localparam logic [CW-1:0] GAP_C = CW'(GAP_W);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_DRIVE, S_GAP, S_SKIP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic            cmd_q, cmd_d;
    logic            q_q, q_d;
    logic            init_q, init_d;
    logic            s_q, s_d;
    logic            r_q, r_d;

    logic [GW-1:0]   idx;
    logic [GW-1:0]   pick;
    logic            found;
    logic [NREQ-1:0] vshift;
    logic [NREQ-1:0] sset;
    logic [NREQ-1:0] ready;
    logic            done;
    logic            skip;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        idx    = '0;
        vshift = '0;
        found  = 1'b0;
        pick   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx    = GW'((int'(rr_q) + i) % NREQ);
            vshift = bus.req_valid >> idx;
            if (!found && vshift[0]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        sset = bus.req_set >> pick;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        cmd_d   = cmd_q;
        q_d     = q_q;
        init_d  = init_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        ready   = '0;
        done    = 1'b0;
        skip    = 1'b0;
        case (state_q)
            // Clear pulse after reset puts the latch into a known Q=0.
            S_INIT: begin
                if (cnt_q == PUL_C) begin
                    state_d = S_GAP;
                    cnt_d   = ONE_C;
                    init_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                    r_d   = 1'b1;
                end
            end
            S_IDLE: begin
                if (found) begin
                    ready = NREQ'(1) << pick;
                    gid_d = pick;
                    cmd_d = sset[0];
                    rr_d  = GW'((int'(pick) + 1) % NREQ);
                    if (sset[0] == q_q) begin
                        state_d = S_SKIP;
                    end else begin
                        state_d = S_DRIVE;
                        cnt_d   = ONE_C;
                        s_d     = sset[0];
                        r_d     = !sset[0];
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == PUL_C) begin
                    state_d = S_GAP;
                    cnt_d   = ONE_C;
                    q_d     = cmd_q;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                    s_d   = cmd_q;
                    r_d   = !cmd_q;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done    = !init_q;
                    init_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_SKIP: begin
                done    = 1'b1;
                skip    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            rr_q    <= '0;
            gid_q   <= '0;
            cmd_q   <= 1'b0;
            q_q     <= 1'b0;
            init_q  <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            cmd_q   <= cmd_d;
            q_q     <= q_d;
            init_q  <= init_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.sr_s      = s_q;
    assign bus.sr_r      = r_q;
    assign bus.q_shadow  = q_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done;
    assign bus.done_id   = done ? gid_q : '0;
    assign bus.done_skip = skip;
endmodule

// File: tb/tb_sr_latch_cmd_sched.sv
// tb/tb_sr_latch_cmd_sched.sv - randomized bench with transaction-level latch scheduler model
module tb_sr_latch_cmd_sched;
    localparam int NR = 4;
    localparam int PW = 2;
    localparam int GP = 1;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    sr_latch_cmd_sched_if #(.NREQ(NR)) ia();
    sr_latch_cmd_sched_if #(.NREQ(1))  ib();

    sr_latch_cmd_sched #(.NREQ(NR), .PULSE_W(PW), .GAP_W(GP)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia)
    );

    sr_latch_cmd_sched #(.NREQ(1), .PULSE_W(1), .GAP_W(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: timeline of the command in flight, expressed as cycle windows.
    int cyc, free_at, p_lo, p_hi, done_at, q_at, d_id, mrr, acc_id;
    int last_pol, low_run;
    bit p_set, q_val, mq, d_skip;
    bit pend[NR];
    bit pset[NR];
    int done_log[$];
    bit skip_log[$];

    task automatic model_reset();
        cyc = 0; p_lo = 1; p_hi = PW; p_set = 1'b0;
        done_at = -1; free_at = PW + GP + 1; q_at = -1; mq = 1'b0;
        mrr = 0; acc_id = -1; last_pol = -1; low_run = 0;
    endtask

    task automatic drive_a();
        logic [NR-1:0] v, s;
        for (int i = 0; i < NR; i++) begin
            v[i] = pend[i];
            s[i] = pset[i];
        end
        ia.req_valid = v;
        ia.req_set   = s;
    endtask

    task automatic model_check();
        logic [NR-1:0] exp_ready;
        bit exp_busy, exp_s, exp_r, exp_done, pol;
        int g;
        if (cyc == q_at) mq = q_val;
        exp_busy = (cyc < free_at);
        exp_s    = p_set && cyc >= p_lo && cyc <= p_hi;
        exp_r    = !p_set && cyc >= p_lo && cyc <= p_hi;
        exp_done = (cyc == done_at);
        exp_ready = '0;
        g = -1;
        if (!exp_busy) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && pend[(mrr + k) % NR]) g = (mrr + k) % NR;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        check_eq("req_ready", ia.req_ready, exp_ready);
        check_eq("sr_s", ia.sr_s, exp_s);
        check_eq("sr_r", ia.sr_r, exp_r);
        check_eq("q_shadow", ia.q_shadow, mq);
        check_eq("busy", ia.busy, exp_busy);
        check_eq("done", ia.done, exp_done);
        check_eq("s_and_r", ia.sr_s & ia.sr_r, 0);
        if (exp_done) begin
            check_eq("done_id", ia.done_id, d_id);
            check_eq("done_skip", ia.done_skip, d_skip);
        end
        if (ia.done) begin
            done_log.push_back(int'(ia.done_id));
            skip_log.push_back(ia.done_skip);
        end
        if (ia.sr_s | ia.sr_r) begin
            pol = ia.sr_s;
            if (last_pol >= 0 && int'(pol) != last_pol) check_eq("dead_gap", low_run >= GP, 1);
            last_pol = int'(pol);
            low_run  = 0;
        end else begin
            low_run++;
        end
        if (g >= 0) begin
            d_id   = g;
            mrr    = (g + 1) % NR;
            acc_id = g;
            if (pset[g] == mq) begin
                d_skip  = 1'b1;
                done_at = cyc + 1;
                free_at = cyc + 2;
                p_lo    = 1;
                p_hi    = 0;
            end else begin
                d_skip  = 1'b0;
                p_set   = pset[g];
                p_lo    = cyc + 1;
                p_hi    = cyc + PW;
                done_at = cyc + PW + GP;
                free_at = done_at + 1;
                q_at    = cyc + PW + 1;
                q_val   = pset[g];
            end
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd, input bit hold);
        for (int t = 0; t < n; t++) begin
            if (acc_id >= 0) begin
                pend[acc_id] = hold;
                acc_id = -1;
            end
            if (rnd) begin
                for (int i = 0; i < NR; i++) begin
                    if (!pend[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            pend[i] = 1'b1;
                            pset[i] = 1'($urandom_range(0, 1));
                        end
                    end else if (cyc < free_at && $urandom_range(0, 15) == 0) begin
                        pend[i] = 1'b0;
                    end
                end
            end
            drive_a();
            #1;
            model_check();
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clear_pend();
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0;
            pset[i] = 1'b0;
        end
        acc_id = -1;
        drive_a();
    endtask

    task automatic apply_reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        clear_pend();
        #1;
        check_eq("rst_sr_s", ia.sr_s, 0);
        check_eq("rst_sr_r", ia.sr_r, 0);
        check_eq("rst_q", ia.q_shadow, 0);
        check_eq("rst_done", ia.done, 0);
        check_eq("rst_done_id", ia.done_id, 0);
        check_eq("rst_skip", ia.done_skip, 0);
        check_eq("rst_ready", ia.req_ready, 0);
        check_eq("rst_busy", ia.busy, 1);
        @(negedge clk);
        rst_a = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, nacc, last, found;
        bit bset, acc_seen;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ib.req_valid = '0;
        ib.req_set   = '0;
        clear_pend();

        // Init pulse then quiet idle.
        apply_reset_a();
        done_log.delete();
        skip_log.delete();
        run_cycles(6, 1'b0, 1'b0);
        check_eq("init_no_done", done_log.size(), 0);
        check_eq("init_busy", ia.busy, 0);

        // Single set from requester 2.
        pend[2] = 1'b1; pset[2] = 1'b1;
        run_cycles(8, 1'b0, 1'b0);
        check_eq("t2_id", done_log.size() > 0 ? done_log[0] : -1, 2);
        check_eq("t2_q", ia.q_shadow, 1);

        // Redundant set from requester 1 is skipped.
        pend[1] = 1'b1; pset[1] = 1'b1;
        run_cycles(4, 1'b0, 1'b0);
        check_eq("t3_id", done_log.size() > 1 ? done_log[1] : -1, 1);
        check_eq("t3_skip", skip_log.size() > 1 ? skip_log[1] : 0, 1);

        // All four held, alternating commands: round-robin order.
        apply_reset_a();
        done_log.delete();
        skip_log.delete();
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b1;
            pset[i] = (i % 2 == 0);
        end
        run_cycles(26, 1'b0, 1'b1);
        check_eq("t4_count", done_log.size() >= 5, 1);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t4_order%0d", k), k < done_log.size() ? done_log[k] : -1, k % NR);
        end

        // Asynchronous reset in the middle of a set pulse.
        apply_reset_a();
        run_cycles(5, 1'b0, 1'b0);
        pend[0] = 1'b1; pset[0] = 1'b1;
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            run_cycles(1, 1'b0, 1'b0);
            if (ia.sr_s) found = 1;
        end
        check_eq("t5_drive_seen", found, 1);
        #2;
        rst_a = 1'b1;
        clear_pend();
        #1;
        check_eq("t5_async_s", ia.sr_s, 0);
        check_eq("t5_async_r", ia.sr_r, 0);
        check_eq("t5_busy", ia.busy, 1);
        check_eq("t5_q", ia.q_shadow, 0);
        @(negedge clk);
        rst_a = 1'b0;
        model_reset();
        n0 = done_log.size();
        run_cycles(8, 1'b0, 1'b0);
        check_eq("t5_no_done", done_log.size(), n0);

        // Randomized traffic.
        n0 = done_log.size();
        run_cycles(600, 1'b1, 1'b0);
        check_eq("rand_activity", done_log.size() > n0 + 20, 1);

        // Single requester, PULSE_W=1, GAP_W=3: accepts every 5 cycles.
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check_eq("b_rst_busy", ib.busy, 1);
        check_eq("b_rst_r", ib.sr_r, 0);
        @(negedge clk);
        rst_b = 1'b0;
        bset = 1'b1;
        ib.req_valid = 1'b1;
        ib.req_set   = bset;
        nacc = 0;
        last = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            acc_seen = 1'b0;
            check_eq("b_s_and_r", ib.sr_s & ib.sr_r, 0);
            if (ib.done) begin
                check_eq("b_done_id", ib.done_id, 0);
                check_eq("b_done_skip", ib.done_skip, 0);
            end
            if (ib.req_ready[0] & ib.req_valid[0]) begin
                if (last < 0) check_eq("b_first_accept", c, 5);
                else          check_eq("b_accept_period", c - last, 5);
                last = c;
                nacc++;
                acc_seen = 1'b1;
            end
            @(negedge clk);
            if (acc_seen) begin
                bset = !bset;
                ib.req_set = bset;
            end
        end
        check_eq("b_accept_count", nacc, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
